// File: rtl/cpu_test_pkg.sv
// Shared types for the CPU self-check harness: FSM states, expectation entries
// and the default datapath widths.
package cpu_test_pkg;

   localparam int CPU_XLEN   = 32;
   localparam int CPU_REG_AW = 5;

   typedef enum logic [2:0] {
      IDLE,
      CPU_RST,
      RUN,
      CHECK,
      DONE
   } selfchk_state_t;

   typedef struct packed {
      logic                  en;
      logic [CPU_REG_AW-1:0] reg_addr;
      logic [CPU_XLEN-1:0]   val;
      logic [CPU_XLEN-1:0]   mask;
   } exp_entry_t;

   // x0 is hardwired, so the observed value is taken as zero whatever the port returns.
   function automatic logic entry_fails(exp_entry_t e, logic [CPU_XLEN-1:0] data);
      logic [CPU_XLEN-1:0] got;
      got = (e.reg_addr == '0) ? '0 : data;
      return e.en && (((got ^ e.val) & e.mask) != '0);
   endfunction

endpackage

// File: rtl/selfchk_exp_table.sv
// Expectation table: NUM_CHECKS entries, one synchronous write port and one
// combinational read port.
module selfchk_exp_table
   import cpu_test_pkg::*;
#(
   parameter int NUM_CHECKS = 8,
   parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  exp_entry_t       wr_entry,
   input  logic [IDX_W-1:0] rd_idx,
   output exp_entry_t       rd_entry
);

   exp_entry_t tbl [NUM_CHECKS];

   // NOTE: only the valid bits are reset; payload fields are don't-care until written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHECKS; i++) tbl[i].en <= 1'b0;
      end else if (we && (int'(wr_idx) < NUM_CHECKS)) begin
         tbl[wr_idx] <= wr_entry;
      end
   end

   assign rd_entry = (int'(rd_idx) < NUM_CHECKS) ? tbl[rd_idx] : '0;

endmodule

// File: rtl/cpu_selfcheck_monitor.sv
// Self-check harness: resets the CPU, runs it for a bounded number of cycles or
// until halt, then walks the expectation table through the debug read port.
module cpu_selfcheck_monitor
   import cpu_test_pkg::*;
#(
   parameter int XLEN       = CPU_XLEN,
   parameter int REG_AW     = CPU_REG_AW,
   parameter int NUM_CHECKS = 8,
   parameter int CYC_W      = 16,
   parameter int RST_CYCLES = 2,
   localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int CNT_W     = $clog2(NUM_CHECKS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CYC_W-1:0]  run_cycles,
   input  logic              cpu_halt,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic              exp_en,
   input  logic [REG_AW-1:0] exp_reg,
   input  logic [XLEN-1:0]   exp_val,
   input  logic [XLEN-1:0]   exp_mask,
   output logic              cpu_rst,
   output logic [REG_AW-1:0] dbg_addr,
   input  logic [XLEN-1:0]   dbg_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timed_out,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [IDX_W-1:0]  first_fail,
   output logic [XLEN-1:0]   first_got
);

   selfchk_state_t   state;
   logic [CYC_W-1:0] run_len;
   logic [CYC_W-1:0] cnt;
   logic [CNT_W-1:0] chk_cnt;
   exp_entry_t       cur_ent;   // entry whose address is on dbg_addr this cycle
   exp_entry_t       cmp_ent;   // entry whose data arrives on dbg_data this cycle
   exp_entry_t       rd_ent;
   exp_entry_t       wr_ent;
   logic [IDX_W-1:0] rd_idx;
   logic             tbl_we;
   logic             mismatch;

   assign tbl_we = exp_we && ((state == IDLE) || (state == DONE));
   assign wr_ent = '{en: exp_en, reg_addr: exp_reg, val: exp_val, mask: exp_mask};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rd_idx = '0;
      if (state == CHECK) rd_idx = IDX_W'(chk_cnt + 1'b1);
   end

   assign mismatch = (state == CHECK) && (chk_cnt != '0) && entry_fails(cmp_ent, dbg_data);

   selfchk_exp_table #(
      .NUM_CHECKS (NUM_CHECKS),
      .IDX_W      (IDX_W)
   ) u_table (
      .clk      (clk),
      .rst      (rst),
      .we       (tbl_we),
      .wr_idx   (exp_idx),
      .wr_entry (wr_ent),
      .rd_idx   (rd_idx),
      .rd_entry (rd_ent)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cpu_rst    <= 1'b1;
         dbg_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         timed_out  <= 1'b0;
         fail_cnt   <= '0;
         first_fail <= '0;
         first_got  <= '0;
         run_len    <= '0;
         cnt        <= '0;
         chk_cnt    <= '0;
         cur_ent    <= '0;
         cmp_ent    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= CPU_RST;
                  cpu_rst    <= 1'b1;
                  run_len    <= run_cycles;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  timed_out  <= 1'b0;
                  fail_cnt   <= '0;
                  first_fail <= '0;
                  first_got  <= '0;
               end
            end
            CPU_RST: begin
               if (cnt == CYC_W'(RST_CYCLES - 1)) begin
                  state   <= RUN;
                  cpu_rst <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               // A halt on the last cycle still counts as a clean halt.
               if (cpu_halt || (run_len == '0) || (cnt == run_len - 1'b1)) begin
                  state     <= CHECK;
                  cpu_rst   <= 1'b1;
                  timed_out <= !cpu_halt;
                  chk_cnt   <= '0;
                  cur_ent   <= rd_ent;
                  dbg_addr  <= rd_ent.reg_addr;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CHECK: begin
               cmp_ent  <= cur_ent;
               cur_ent  <= rd_ent;
               dbg_addr <= rd_ent.reg_addr;
               chk_cnt  <= chk_cnt + 1'b1;
               if (mismatch) begin
                  if (fail_cnt == '0) begin
                     first_fail <= IDX_W'(chk_cnt - 1'b1);
                     first_got  <= dbg_data;
                  end
                  if (fail_cnt != CNT_W'(NUM_CHECKS)) fail_cnt <= fail_cnt + 1'b1;
               end
               if (chk_cnt == CNT_W'(NUM_CHECKS)) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  dbg_addr <= '0;
                  pass     <= !timed_out && (fail_cnt == '0) && !mismatch;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_selfcheck_monitor.sv
// Directed bench for cpu_selfcheck_monitor with a registered register-file model
// behind the debug port.
module tb_cpu_selfcheck_monitor;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int NUM_CHECKS = 8;
   localparam int CYC_W      = 16;
   localparam int RST_CYCLES = 2;
   localparam int IDX_W      = 3;
   localparam int CNT_W      = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CYC_W-1:0]  run_cycles;
   logic              cpu_halt;
   logic              exp_we;
   logic [IDX_W-1:0]  exp_idx;
   logic              exp_en;
   logic [REG_AW-1:0] exp_reg;
   logic [XLEN-1:0]   exp_val;
   logic [XLEN-1:0]   exp_mask;
   logic              cpu_rst;
   logic [REG_AW-1:0] dbg_addr;
   logic [XLEN-1:0]   dbg_data;
   logic              busy;
   logic              done;
   logic              pass;
   logic              timed_out;
   logic [CNT_W-1:0]  fail_cnt;
   logic [IDX_W-1:0]  first_fail;
   logic [XLEN-1:0]   first_got;

   logic [XLEN-1:0]   rf [32];
   int                n_vec = 0;
   int                n_miss = 0;

   always #5 clk = ~clk;

   // Register file with a registered debug read port; x0 deliberately returns junk.
   always @(posedge clk) dbg_data <= rf[dbg_addr];

   cpu_selfcheck_monitor #(
      .XLEN       (XLEN),
      .REG_AW     (REG_AW),
      .NUM_CHECKS (NUM_CHECKS),
      .CYC_W      (CYC_W),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .run_cycles (run_cycles),
      .cpu_halt   (cpu_halt),
      .exp_we     (exp_we),
      .exp_idx    (exp_idx),
      .exp_en     (exp_en),
      .exp_reg    (exp_reg),
      .exp_val    (exp_val),
      .exp_mask   (exp_mask),
      .cpu_rst    (cpu_rst),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .timed_out  (timed_out),
      .fail_cnt   (fail_cnt),
      .first_fail (first_fail),
      .first_got  (first_got)
   );

   task automatic write_exp(input int idx, input logic en, input logic [REG_AW-1:0] r,
                            input logic [XLEN-1:0] v, input logic [XLEN-1:0] m);
      @(negedge clk);
      exp_we = 1'b1; exp_idx = IDX_W'(idx); exp_en = en; exp_reg = r; exp_val = v; exp_mask = m;
      @(negedge clk);
      exp_we = 1'b0;
   endtask

   // Start, wait for reset release, optionally halt after halt_at RUN cycles, wait for done.
   task automatic run_to_done(input logic [CYC_W-1:0] rc, input int halt_at, output bit ok);
      int guard;
      @(negedge clk);
      run_cycles = rc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (cpu_rst && guard < 50) begin @(negedge clk); guard++; end
      if (halt_at >= 0) begin
         repeat (halt_at) @(negedge clk);
         cpu_halt = 1'b1;
         @(negedge clk);
         cpu_halt = 1'b0;
      end
      guard = 0;
      while (!done && guard < 200) begin @(negedge clk); guard++; end
      ok = done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (cpu_rst !== 1'b1) begin n_miss++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done got=%b exp=0", done); end
      n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL reset_pass got=%b exp=0", pass); end
      n_vec++; if (timed_out !== 1'b0) begin n_miss++; $display("FAIL reset_timed_out got=%b exp=0", timed_out); end
      n_vec++; if (dbg_addr !== 5'd0) begin n_miss++; $display("FAIL reset_dbg_addr got=%0d exp=0", dbg_addr); end
      n_vec++; if (fail_cnt !== 4'd0) begin n_miss++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
      n_vec++; if (first_fail !== 3'd0) begin n_miss++; $display("FAIL reset_first_fail got=%0d exp=0", first_fail); end
      n_vec++; if (first_got !== 32'd0) begin n_miss++; $display("FAIL reset_first_got got=%h exp=0", first_got); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_all_match();
      bit ok;
      write_exp(0, 1'b1, 5'd1, 32'd10,         32'hFFFF_FFFF);
      write_exp(1, 1'b1, 5'd2, 32'hFFFF_FF00,  32'hFFFF_FFFF);
      write_exp(2, 1'b1, 5'd3, 32'd20,         32'hFFFF_FFFF);
      write_exp(3, 1'b1, 5'd3, 32'd20,         32'hFFFF_FFFF);
      write_exp(4, 1'b1, 5'd0, 32'd0,          32'hFFFF_FFFF);
      write_exp(5, 1'b1, 5'd5, 32'h55,         32'hFFFF_FFFF);
      write_exp(6, 1'b1, 5'd2, 32'h0,          32'h0000_00FF);
      write_exp(7, 1'b0, 5'd1, 32'd999,        32'hFFFF_FFFF);
      run_to_done(16'd100, 12, ok);
      n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL match_done got=%b exp=1", ok); end
      n_vec++; if (pass !== 1'b1) begin n_miss++; $display("FAIL match_pass got=%b exp=1", pass); end
      n_vec++; if (fail_cnt !== 4'd0) begin n_miss++; $display("FAIL match_fail_cnt got=%0d exp=0", fail_cnt); end
      n_vec++; if (timed_out !== 1'b0) begin n_miss++; $display("FAIL match_timed_out got=%b exp=0", timed_out); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL match_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single_mismatch();
      bit ok;
      write_exp(3, 1'b1, 5'd3, 32'd21, 32'hFFFF_FFFF);
      run_to_done(16'd100, 2, ok);
      n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL mis_done got=%b exp=1", ok); end
      n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL mis_pass got=%b exp=0", pass); end
      n_vec++; if (fail_cnt !== 4'd1) begin n_miss++; $display("FAIL mis_fail_cnt got=%0d exp=1", fail_cnt); end
      n_vec++; if (first_fail !== 3'd3) begin n_miss++; $display("FAIL mis_first_fail got=%0d exp=3", first_fail); end
      n_vec++; if (first_got !== 32'd20) begin n_miss++; $display("FAIL mis_first_got got=%0d exp=20", first_got); end
      write_exp(3, 1'b1, 5'd3, 32'd20, 32'hFFFF_FFFF);
   endtask

   task automatic test_mask();
      bit ok;
      write_exp(6, 1'b1, 5'd2, 32'h0, 32'hFFFF_FFFF);
      run_to_done(16'd100, 3, ok);
      n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL mask_done got=%b exp=1", ok); end
      n_vec++; if (fail_cnt !== 4'd1) begin n_miss++; $display("FAIL mask_fail_cnt got=%0d exp=1", fail_cnt); end
      n_vec++; if (first_fail !== 3'd6) begin n_miss++; $display("FAIL mask_first_fail got=%0d exp=6", first_fail); end
      n_vec++; if (first_got !== 32'hFFFF_FF00) begin n_miss++; $display("FAIL mask_first_got got=%h exp=ffffff00", first_got); end
      n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL mask_pass got=%b exp=0", pass); end
      write_exp(6, 1'b1, 5'd2, 32'h0, 32'h0000_00FF);
   endtask

   // run_cycles=10 with no halt; exp_we during RUN must be ignored.
   task automatic test_timeout();
      int n_hi = 0, n_lo = 0, k_chk = -1, guard = 0;
      @(negedge clk);
      run_cycles = 16'd10; start = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0; exp_we = 1'b0;
         if (!cpu_rst) begin
            n_lo++;
            if (n_lo == 1) begin
               exp_we = 1'b1; exp_idx = 3'd0; exp_en = 1'b1; exp_reg = 5'd1;
               exp_val = 32'd999; exp_mask = 32'hFFFF_FFFF;
            end
         end else if (n_lo == 0) begin
            n_hi++;
         end else begin
            k_chk = k;
            break;
         end
      end
      exp_we = 1'b0;
      // k counts negedges from the start edge itself, so cycles since start = k - 1.
      n_vec++; if (n_hi !== RST_CYCLES) begin n_miss++; $display("FAIL to_rst_len got=%0d exp=%0d", n_hi, RST_CYCLES); end
      n_vec++; if (n_lo !== 10) begin n_miss++; $display("FAIL to_run_len got=%0d exp=10", n_lo); end
      n_vec++; if (k_chk - 1 !== RST_CYCLES + 10) begin n_miss++; $display("FAIL to_check_entry got=%0d exp=%0d", k_chk - 1, RST_CYCLES + 10); end
      while (!done && guard < 50) begin @(negedge clk); guard++; end
      n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL to_done got=%b exp=1", done); end
      n_vec++; if (timed_out !== 1'b1) begin n_miss++; $display("FAIL to_timed_out got=%b exp=1", timed_out); end
      n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL to_pass got=%b exp=0", pass); end
      n_vec++; if (fail_cnt !== 4'd0) begin n_miss++; $display("FAIL to_we_ignored fail_cnt got=%0d exp=0", fail_cnt); end
   endtask

   // Halt on the last RUN cycle, then pulse start during CHECK.
   task automatic test_halt_last();
      int n_lo = 0, halt_k = -1, chk_k = -1, done_k = -1;
      @(negedge clk);
      run_cycles = 16'd10; start = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0; cpu_halt = 1'b0;
         if (done) begin done_k = k; break; end
         if (!cpu_rst) begin
            n_lo++;
            if (n_lo == 10) begin cpu_halt = 1'b1; halt_k = k; end
         end else if (n_lo > 0 && chk_k < 0) begin
            chk_k = k;
            start = 1'b1;
         end
      end
      start = 1'b0; cpu_halt = 1'b0;
      n_vec++; if (chk_k - halt_k !== 1) begin n_miss++; $display("FAIL hl_check_entry got=%0d exp=1", chk_k - halt_k); end
      // First CHECK cycle is halt_k+1; NUM_CHECKS+1 CHECK cycles, then DONE is visible.
      n_vec++; if (done_k - halt_k !== NUM_CHECKS + 2) begin n_miss++; $display("FAIL hl_done_latency got=%0d exp=%0d", done_k - halt_k, NUM_CHECKS + 2); end
      n_vec++; if (timed_out !== 1'b0) begin n_miss++; $display("FAIL hl_timed_out got=%b exp=0", timed_out); end
      n_vec++; if (pass !== 1'b1) begin n_miss++; $display("FAIL hl_pass got=%b exp=1", pass); end
      repeat (3) @(negedge clk);
      n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL hl_start_ignored done got=%b exp=1", done); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL hl_start_ignored busy got=%b exp=0", busy); end
   endtask

   task automatic test_zero_run();
      int n_lo = 0, guard = 0;
      @(negedge clk);
      run_cycles = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && guard < 60) begin
         @(negedge clk);
         guard++;
         if (!cpu_rst) n_lo++;
      end
      n_vec++; if (n_lo !== 1) begin n_miss++; $display("FAIL zero_run_len got=%0d exp=1", n_lo); end
      n_vec++; if (timed_out !== 1'b1) begin n_miss++; $display("FAIL zero_timed_out got=%b exp=1", timed_out); end
      n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL zero_done got=%b exp=1", done); end
   endtask

   task automatic test_rst_mid_run();
      bit ok;
      int guard = 0;
      write_exp(3, 1'b1, 5'd3, 32'd21, 32'hFFFF_FFFF);
      @(negedge clk);
      run_cycles = 16'd50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cpu_rst && guard < 20) begin @(negedge clk); guard++; end
      repeat (3) @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (cpu_rst !== 1'b1) begin n_miss++; $display("FAIL rst_cpu_rst got=%b exp=1", cpu_rst); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL rst_done got=%b exp=0", done); end
      // All entries disabled by reset: the stale mismatching entry 3 must not count.
      run_to_done(16'd3, -1, ok);
      n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL rst_after_done got=%b exp=1", ok); end
      n_vec++; if (fail_cnt !== 4'd0) begin n_miss++; $display("FAIL rst_en_cleared fail_cnt got=%0d exp=0", fail_cnt); end
      n_vec++; if (timed_out !== 1'b1) begin n_miss++; $display("FAIL rst_after_timed_out got=%b exp=1", timed_out); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; run_cycles = '0; cpu_halt = 1'b0;
      exp_we = 1'b0; exp_idx = '0; exp_en = 1'b0; exp_reg = '0; exp_val = '0; exp_mask = '0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[0] = 32'hDEAD_BEEF;
      rf[1] = 32'd10;
      rf[2] = 32'hFFFF_FF00;
      rf[3] = 32'd20;
      rf[5] = 32'h55;
      test_reset();
      test_all_match();
      test_single_mismatch();
      test_mask();
      test_timeout();
      test_halt_last();
      test_zero_run();
      test_rst_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
